// File: rtl/flash_log_pkg.sv
// Shared constants, state encoding and address-advance helper
// for the flash record logger.
package flash_log_pkg;

  localparam logic [7:0] CMD_WREN      = 8'h06;
  localparam logic [7:0] CMD_SE        = 8'hD8;
  localparam logic [7:0] CMD_MEM_WRITE = 8'h11;
  localparam logic [7:0] CMD_FREAD     = 8'h0B;

  localparam int         REC_BYTES = 6;
  localparam logic [7:0] PAGE_LAST = 8'd250;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WREN,
    S_SE,
    S_WR,
    S_RD,
    S_CMP,
    S_FULL
  } state_t;

  // A record never straddles a page: the last 4 bytes of each
  // page are skipped.
  function automatic logic [23:0] next_addr(
    input logic [23:0] a
  );
    logic [23:0] n;
    n = a + 24'(REC_BYTES);
    if (n[7:0] > PAGE_LAST)
      n = {a[23:8] + 16'd1, 8'h00};
    return n;
  endfunction

endpackage

// File: rtl/flash_log_fifo.sv
// Record buffer: synchronous FIFO with first-word-fall-through
// head, full/empty flags and a synchronous flush.
module flash_log_fifo
  import flash_log_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 48
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic         do_push;
  logic         do_pop;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign head  = mem[rp[AW-1:0]];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge CLK) begin
    if (reset || flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/flash_record_logger.sv
// Appends buffered 48-bit records to a sector-erased flash log.
// Optional write readback/compare: FLASH_LOG_READBACK_EN.
module flash_record_logger
  import flash_log_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR  = 24'h100000,
  parameter logic [23:0] END_ADDR   = 24'h200000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        rec_valid,
  input  logic [47:0] rec_data,
  output logic        rec_ready,
  output logic [7:0]  mem_cmd,
  output logic [23:0] mem_addr,
  output logic [47:0] mem_val,
  output logic        mem_trig,
  output logic        mem_quad,
  input  logic        mem_busy,
  input  logic [47:0] mem_data,
  output logic [23:0] wr_addr,
  output logic        log_full,
  output logic [15:0] rec_count,
  output logic        err
);

  state_t      state;
  state_t      state_nx;
  logic        fifo_full;
  logic        fifo_empty;
  logic [47:0] head;
  logic        push;
  logic        pop;
  logic        flush;
  logic        issued;
  logic        is_cmd;
  logic        start;
  logic        done;
  logic        wr_done;
  logic [7:0]  cmd_sel;
  logic [23:0] addr_sel;

`ifdef FLASH_LOG_READBACK_EN
  logic [23:0] sh_addr;
  logic [47:0] sh_data;
`endif

  assign mem_quad  = 1'b0;
  assign log_full  = (state == S_FULL);
  assign rec_ready = !reset && !fifo_full && !log_full;
  assign push      = rec_valid && rec_ready;

  flash_log_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (48)
  ) u_fifo (
    .CLK   (CLK),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (rec_data),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign is_cmd = (state == S_WREN) ||
                  (state == S_SE)   ||
                  (state == S_WR)   ||
                  (state == S_RD);

  // issued marks a command whose trigger has gone out; it ends
  // once the trigger is down and the controller is idle.
  assign start   = is_cmd && !issued && !mem_busy;
  assign done    = issued && !mem_trig && !mem_busy;
  assign wr_done = (state == S_WR) && done;

  always_comb begin
    cmd_sel  = CMD_WREN;
    addr_sel = wr_addr;
    unique case (1'b1)
      (state == S_SE): cmd_sel = CMD_SE;
      (state == S_WR): cmd_sel = CMD_MEM_WRITE;
`ifdef FLASH_LOG_READBACK_EN
      (state == S_RD): begin
        cmd_sel  = CMD_FREAD;
        addr_sel = sh_addr;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      mem_trig <= 1'b0;
      issued   <= 1'b0;
      mem_cmd  <= '0;
      mem_addr <= '0;
      mem_val  <= '0;
    end else if (start) begin
      mem_trig <= 1'b1;
      issued   <= 1'b1;
      mem_cmd  <= cmd_sel;
      mem_addr <= addr_sel;
      if (state == S_WR) mem_val <= head;
    end else if (mem_trig && mem_busy) begin
      mem_trig <= 1'b0;
    end else if (done) begin
      issued   <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    flush    = 1'b0;
    case (state)
      S_IDLE: begin
        if (wr_addr == END_ADDR)
          state_nx = S_FULL;
        else if (!fifo_empty)
          state_nx = (wr_addr[15:0] == 16'h0) ?
                     S_WREN : S_WR;
      end
      S_WREN: if (done) state_nx = S_SE;
      S_SE:   if (done) state_nx = S_WR;
      S_WR: begin
        if (done) begin
          pop = 1'b1;
`ifdef FLASH_LOG_READBACK_EN
          state_nx = S_RD;
`else
          state_nx = S_IDLE;
`endif
        end
      end
`ifdef FLASH_LOG_READBACK_EN
      S_RD:  if (done) state_nx = S_CMP;
      S_CMP: state_nx = S_IDLE;
`endif
      S_FULL: flush = 1'b1;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_addr   <= BASE_ADDR;
      rec_count <= '0;
    end else if (wr_done) begin
      wr_addr <= next_addr(wr_addr);
      if (rec_count != 16'hFFFF)
        rec_count <= rec_count + 16'd1;
    end
  end

`ifdef FLASH_LOG_READBACK_EN
  always_ff @(posedge CLK) begin
    if (reset) begin
      sh_addr <= '0;
      sh_data <= '0;
      err     <= 1'b0;
    end else begin
      if (wr_done) begin
        sh_addr <= wr_addr;
        sh_data <= head;
      end
      if (state == S_CMP && mem_data != sh_data)
        err <= 1'b1;
    end
  end
`else
  logic unused_data;
  assign unused_data = ^mem_data;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_flash_record_logger.sv
// Randomized directed bench for flash_record_logger against a
// behavioural flash controller and a record-address scoreboard.
module tb_flash_record_logger;

  localparam logic [23:0] BASE  = 24'h100000;
  localparam logic [23:0] ENDA  = 24'h110000;
  localparam int          LIMIT = 42 * 256;

  logic        CLK = 1'b0;
  logic        reset;
  logic        rec_valid;
  logic [47:0] rec_data;
  logic        rec_ready;
  logic [7:0]  mem_cmd;
  logic [23:0] mem_addr;
  logic [47:0] mem_val;
  logic        mem_trig;
  logic        mem_quad;
  logic        mem_busy;
  logic [47:0] mem_data;
  logic [23:0] wr_addr;
  logic        log_full;
  logic [15:0] rec_count;
  logic        err;

  always #5 CLK = ~CLK;

  flash_record_logger #(
    .BASE_ADDR  (BASE),
    .END_ADDR   (ENDA),
    .FIFO_DEPTH (8)
  ) dut (
    .CLK       (CLK),
    .reset     (reset),
    .rec_valid (rec_valid),
    .rec_data  (rec_data),
    .rec_ready (rec_ready),
    .mem_cmd   (mem_cmd),
    .mem_addr  (mem_addr),
    .mem_val   (mem_val),
    .mem_trig  (mem_trig),
    .mem_quad  (mem_quad),
    .mem_busy  (mem_busy),
    .mem_data  (mem_data),
    .wr_addr   (wr_addr),
    .log_full  (log_full),
    .rec_count (rec_count),
    .err       (err)
  );

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] expv);
    ntests++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, expv);
    end
  endtask

  // Behavioural flash controller
  bit          hold  = 0;
  bit          stall = 0;
  bit          fast  = 0;
  logic [23:0] corrupt_addr = 24'hFFFFFF;
  int          cnt   = 0;
  logic        m_trig_d = 1'b0;
  logic [47:0] rdata = '0;
  logic [47:0] mem [int];

  assign mem_busy = (mem_trig && !(stall && mem_cmd == 8'h11)) ||
                    (cnt != 0) || hold;
  assign mem_data = rdata;

  always @(posedge CLK) begin
    m_trig_d <= mem_trig;
    if (cnt != 0) cnt <= cnt - 1;
    if (mem_trig && !m_trig_d) begin
      cnt <= (fast || stall) ? 0 : int'($urandom_range(0, 3));
      if (mem_cmd == 8'h11)
        mem[int'(mem_addr)] = mem_val;
      if (mem_cmd == 8'h0B)
        rdata <= mem[int'(mem_addr)] ^
                 ((mem_addr == corrupt_addr) ? 48'h1 : 48'h0);
    end
  end

  // Scoreboard of expected commands
  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] addr;
    logic [47:0] val;
    bit          ck_addr;
    bit          ck_val;
  } cmd_t;

  cmd_t        exp_q [$];
  logic [47:0] hist [int];
  int          rec_idx = 0;

  function automatic logic [23:0] addr_of(input int n);
    return BASE + 24'((n / 42) * 256 + (n % 42) * 6);
  endfunction

  task automatic model_push(input logic [47:0] d);
    logic [23:0] a;
    cmd_t c;
    a = addr_of(rec_idx);
    hist[rec_idx] = d;
    if (rec_idx < LIMIT) begin
      if (a[15:0] == 16'h0) begin
        c = '{8'h06, a, '0, 0, 0};
        exp_q.push_back(c);
        c = '{8'hD8, a, '0, 1, 0};
        exp_q.push_back(c);
      end
      c = '{8'h11, a, d, 1, 1};
      exp_q.push_back(c);
`ifdef FLASH_LOG_READBACK_EN
      c = '{8'h0B, a, '0, 1, 0};
      exp_q.push_back(c);
`endif
    end
    rec_idx++;
  endtask

  // Command monitor
  logic p_trig = 1'b0;
  logic p_busy = 1'b0;
  bit   active = 0;
  cmd_t hld;
  cmd_t e;

  always @(negedge CLK) begin
    if (reset) begin
      active = 0;
    end else begin
      if (mem_trig && !p_trig) begin
        chk("trig_rise_busy", 64'(p_busy), 64'(0));
        chk("cmd_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("cmd", 64'(mem_cmd), 64'(e.cmd));
          if (e.ck_addr)
            chk("cmd_addr", 64'(mem_addr), 64'(e.addr));
          if (e.ck_val)
            chk("cmd_val", 64'(mem_val), 64'(e.val));
        end
        hld = '{mem_cmd, mem_addr, mem_val, 1, 1};
        active = 1;
      end else if (active) begin
        chk("stable_cmd", 64'(mem_cmd), 64'(hld.cmd));
        chk("stable_addr", 64'(mem_addr), 64'(hld.addr));
        chk("stable_val", 64'(mem_val), 64'(hld.val));
        if (!mem_trig && !mem_busy) active = 0;
      end
    end
    p_trig = mem_trig;
    p_busy = mem_busy;
  end

  task automatic push(input logic [47:0] d,
                      input int bound,
                      output bit ok);
    @(posedge CLK);
    #1;
    rec_valid = 1'b1;
    rec_data  = d;
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge CLK);
      if (rec_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge CLK);
    #1;
    rec_valid = 1'b0;
    if (ok) model_push(d);
  endtask

  task automatic drain();
    bit fin;
    fin = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge CLK);
      if (exp_q.size() == 0 && !active &&
          !mem_trig && !mem_busy) begin
        fin = 1;
        break;
      end
    end
    chk("drain_done", 64'(fin), 64'(1));
    repeat (4) @(negedge CLK);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_trig"}, 64'(mem_trig), 64'(0));
    chk({tag, "_cmd"}, 64'(mem_cmd), 64'(0));
    chk({tag, "_addr"}, 64'(mem_addr), 64'(0));
    chk({tag, "_val"}, 64'(mem_val), 64'(0));
    chk({tag, "_ready"}, 64'(rec_ready), 64'(0));
    chk({tag, "_wr_addr"}, 64'(wr_addr), 64'(BASE));
    chk({tag, "_full"}, 64'(log_full), 64'(0));
    chk({tag, "_count"}, 64'(rec_count), 64'(0));
    chk({tag, "_err"}, 64'(err), 64'(0));
    chk({tag, "_quad"}, 64'(mem_quad), 64'(0));
  endtask

  function automatic logic [47:0] rnd48();
    return {16'($urandom), 32'($urandom)};
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: observed running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    bit ok;
    bit seen;
    int base_cnt;

    reset     = 1'b1;
    rec_valid = 1'b0;
    rec_data  = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_reset_vals("rst");
    @(posedge CLK);
    #1;
    reset = 1'b0;

    // First record: erase then write at BASE
    push(48'hA5A5_0000_0001, 20, ok);
    chk("first_push", 64'(ok), 64'(1));
    drain();
    chk("first_count", 64'(rec_count), 64'(1));
    chk("first_wr_addr", 64'(wr_addr), 64'(24'h100006));
    chk("first_mem", 64'(mem[int'(BASE)]),
        64'(48'hA5A5_0000_0001));
    chk("err_clean", 64'(err), 64'(0));

    // 43 records across the first page boundary
    for (int k = 0; k < 43; k++) begin
      push(rnd48(), 200, ok);
      chk("page_push", 64'(ok), 64'(1));
      repeat ($urandom_range(0, 2)) @(posedge CLK);
    end
    drain();
    chk("page_count", 64'(rec_count), 64'(44));
    chk("page_wr_addr", 64'(wr_addr), 64'(addr_of(44)));
    chk("slot41", 64'(mem[int'(24'h1000F6)]), 64'(hist[41]));
    chk("slot42", 64'(mem[int'(24'h100100)]), 64'(hist[42]));
    chk("gap_unwritten",
        64'(mem.exists(int'(24'h1000FC))), 64'(0));

    // Controller stuck busy with a full fifo
    @(posedge CLK);
    #1;
    hold = 1;
    for (int k = 0; k < 8; k++) begin
      push(rnd48(), 20, ok);
      chk("hold_push", 64'(ok), 64'(1));
    end
    @(negedge CLK);
    chk("hold_ready", 64'(rec_ready), 64'(0));
    push(rnd48(), 50, ok);
    chk("hold_refused", 64'(ok), 64'(0));
    chk("hold_no_trig", 64'(mem_trig), 64'(0));
    @(posedge CLK);
    #1;
    hold = 0;
    drain();
    chk("hold_count", 64'(rec_count), 64'(52));
    chk("hold_wr_addr", 64'(wr_addr), 64'(addr_of(52)));

`ifdef FLASH_LOG_READBACK_EN
    corrupt_addr = addr_of(rec_idx);
    push(rnd48(), 50, ok);
    drain();
    chk("rb_err_set", 64'(err), 64'(1));
    for (int k = 0; k < 3; k++) push(rnd48(), 50, ok);
    drain();
    chk("rb_err_sticky", 64'(err), 64'(1));
    chk("rb_count", 64'(rec_count), 64'(56));
    chk("rb_after_mem", 64'(mem[int'(addr_of(55))]),
        64'(hist[55]));
    corrupt_addr = 24'hFFFFFF;
`else
    chk("err_tied", 64'(err), 64'(0));
`endif

    // Fill the region to its end
    fast = 1;
    while (rec_idx < LIMIT + 3) begin
      base_cnt = rec_idx;
      push(rnd48(), 200, ok);
      if (base_cnt < LIMIT)
        chk("fill_push", 64'(ok), 64'(1));
      if (!ok) break;
    end
    seen = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge CLK);
      if (log_full) begin
        seen = 1;
        break;
      end
    end
    chk("full_flag", 64'(seen), 64'(1));
    chk("full_ready", 64'(rec_ready), 64'(0));
    chk("full_count", 64'(rec_count), 64'(LIMIT));
    chk("full_wr_addr", 64'(wr_addr), 64'(ENDA));
    chk("full_exp_left", 64'(exp_q.size()), 64'(0));
    push(rnd48(), 20, ok);
    chk("full_refused", 64'(ok), 64'(0));
    repeat (10) @(negedge CLK);
    chk("full_no_trig", 64'(mem_trig), 64'(0));
    chk("full_sticky", 64'(log_full), 64'(1));
    fast = 0;

    // Reset to leave FULL, then reset again in the middle of a write
    @(posedge CLK);
    #1;
    reset = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #1;
    reset = 1'b0;
    rec_idx = 0;
    stall = 1;
    push(48'h0123_4567_89AB, 20, ok);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (mem_trig && mem_cmd == 8'h11) begin
        seen = 1;
        break;
      end
    end
    chk("mid_wr_reached", 64'(seen), 64'(1));
    @(posedge CLK);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge CLK);
    @(negedge CLK);
    chk_reset_vals("mid");
    @(posedge CLK);
    #1;
    reset = 1'b0;
    stall = 0;
    rec_idx = 0;
    push(rnd48(), 50, ok);
    push(rnd48(), 50, ok);
    drain();
    chk("restart_count", 64'(rec_count), 64'(2));
    chk("restart_wr_addr", 64'(wr_addr), 64'(BASE + 24'd12));
    chk("restart_mem", 64'(mem[int'(BASE)]), 64'(hist[0]));
    chk("final_exp_left", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
